// File: rtl/ct_f_spsram_arb_ctrl.sv
// Round-robin access controller sharing one 1024x92 single-port SRAM between two requesters.
// Define CT_F_SPSRAM_ARB_INIT_EN to zero the whole array after reset before any grant.
module ct_f_spsram_arb_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BANK_WIDTH = 23,
    parameter int unsigned BANK_NUM   = 4,
    localparam int unsigned DATA_WIDTH = BANK_WIDTH * BANK_NUM
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0_vld,
    output logic                  req0_rdy,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [BANK_NUM-1:0]   req0_bwen,
    output logic                  rsp0_vld,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_vld,
    output logic                  req1_rdy,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [BANK_NUM-1:0]   req1_bwen,
    output logic                  rsp1_vld,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    logic                  in_init;
    logic                  run;
    logic                  gnt0;
    logic                  gnt1;
    logic                  g_wr;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [BANK_NUM-1:0]   g_bwen;
    logic                  rr_q, rr_d;
    logic                  rsp0_vld_q, rsp0_vld_d;
    logic                  rsp1_vld_q, rsp1_vld_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;

`ifdef CT_F_SPSRAM_ARB_INIT_EN
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // Zero sweep walks every address once, then hands over to normal operation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (&cnt_q) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_init = ~RST & (state_q == ST_INIT);
    assign run     = ~RST & (state_q == ST_RUN);
`else
    assign in_init = 1'b0;
    assign run     = ~RST;
`endif

    // rr_q = 1 means requester 1 is favoured on a tie.
    assign gnt0 = run & req0_vld & (~req1_vld | ~rr_q);
    assign gnt1 = run & req1_vld & (~req0_vld | rr_q);

    assign g_wr    = gnt1 ? req1_wr    : req0_wr;
    assign g_addr  = gnt1 ? req1_addr  : req0_addr;
    assign g_wdata = gnt1 ? req1_wdata : req0_wdata;
    assign g_bwen  = gnt1 ? req1_bwen  : req0_bwen;

    // SRAM drive; address and data hold their last value when idle.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        a_d       = a_q;
        d_d       = d_q;
        if (in_init) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
`ifdef CT_F_SPSRAM_ARB_INIT_EN
            a_d       = cnt_q;
`endif
            d_d       = '0;
        end else if (gnt0 | gnt1) begin
            sram_cen = 1'b0;
            a_d      = g_addr;
            d_d      = g_wdata;
            if (g_wr) begin
                sram_gwen = ~(|g_bwen);
                for (int b = 0; b < int'(BANK_NUM); b++) begin
                    sram_wen[b*BANK_WIDTH +: BANK_WIDTH] = {BANK_WIDTH{~g_bwen[b]}};
                end
            end
        end
    end

    always_comb begin
        rr_d       = rr_q;
        rsp0_vld_d = gnt0 & ~req0_wr;
        rsp1_vld_d = gnt1 & ~req1_wr;
        if (gnt0) begin
            rr_d = 1'b1;
        end else if (gnt1) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_q       <= 1'b0;
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            a_q        <= '0;
            d_q        <= '0;
        end else begin
            rr_q       <= rr_d;
            rsp0_vld_q <= rsp0_vld_d;
            rsp1_vld_q <= rsp1_vld_d;
            a_q        <= a_d;
            d_q        <= d_d;
        end
    end

    assign req0_rdy   = gnt0;
    assign req1_rdy   = gnt1;
    assign rsp0_vld   = rsp0_vld_q;
    assign rsp1_vld   = rsp1_vld_q;
    assign rsp0_rdata = sram_q;
    assign rsp1_rdata = sram_q;
    assign init_done  = run;
    assign sram_a     = a_d;
    assign sram_d     = d_d;

endmodule
